ahb_slave_pipe: RTL and testbench

AHB_SLAVE_PIPE -- requirements
Module: ahb_slave_pipe

---
 rtl/ahb_slv_pkg.sv | 28 ++
 rtl/ahb_addr_decode.sv | 40 ++++
 rtl/ahb_slave_pipe.sv | 119 +++++++++++
 tb/tb_ahb_slave_pipe.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_slv_pkg.sv
// Shared encodings for the AHB slave pipeline: HTRANS/HRESP codes and the
// error-response state type.
package ahb_slv_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } err_st_e;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic trans_active(input logic [1:0] t);
    return t[1];
  endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Region decoder: flags in-range active transfers and one-hot selects the
// REGION_SIZE-aligned slot counted from BASE_ADDR.
module ahb_addr_decode
  import ahb_slv_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              NUM_SEL     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] REGION_SIZE = 32'h0400_0000
) (
  input  logic               hready_in,
  input  logic [1:0]         htrans,
  input  logic [ADDR_W-1:0]  haddr,
  output logic               valid,
  output logic [NUM_SEL-1:0] temp_sel
);

  localparam int SH = $clog2(REGION_SIZE);
  // One extra bit keeps the upper bound from wrapping at the top of the map.
  localparam logic [ADDR_W:0] LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] HI = LO + (ADDR_W+1)'(NUM_SEL) * {1'b0, REGION_SIZE};

  logic [ADDR_W:0]   addr_x;
  logic              in_range;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] region;

  always_comb begin
    addr_x   = {1'b0, haddr};
    in_range = (addr_x >= LO) && (addr_x < HI);
    valid    = hready_in & trans_active(htrans) & in_range;
    offset   = haddr - BASE_ADDR;
    region   = offset >> SH;
    temp_sel = '0;
    for (int k = 0; k < NUM_SEL; k++) begin
      if (valid && (region == ADDR_W'(k))) temp_sel[k] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_slave_pipe.sv
// AHB slave front end: address decode, hready-gated address/data pipeline and
// optional two-cycle ERROR response (enabled by AHB_SLV_ERR_RESP_EN).
module ahb_slave_pipe
  import ahb_slv_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SEL     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] REGION_SIZE = 32'h0400_0000,
  parameter int                PIPE_DEPTH  = 2
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               hwrite,
  input  logic               hready_in,
  input  logic [1:0]         htrans,
  input  logic [ADDR_W-1:0]  haddr,
  input  logic [DATA_W-1:0]  hwdata,
  input  logic               bridge_busy,
  output logic               hready_out,
  output logic [1:0]         hresp,
  output logic               valid,
  output logic [NUM_SEL-1:0] temp_sel,
  output logic [ADDR_W-1:0]  haddr_q,
  output logic [DATA_W-1:0]  hwdata_q,
  output logic               hwrite_q,
  output logic               valid_q
);

  // Write data trails its address phase by one beat, so it needs one stage less.
  localparam int DD = PIPE_DEPTH - 1;

  ahb_addr_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_SEL     (NUM_SEL),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_SIZE (REGION_SIZE)
  ) u_dec (
    .hready_in (hready_in),
    .htrans    (htrans),
    .haddr     (haddr),
    .valid     (valid),
    .temp_sel  (temp_sel)
  );

  logic [PIPE_DEPTH-1:0][ADDR_W-1:0] addr_d, addr_q;
  logic [PIPE_DEPTH-1:0]             wr_d, wr_q;
  logic [PIPE_DEPTH-1:0]             vld_d, vld_q;
  logic [DD-1:0][DATA_W-1:0]         data_d, data_q;

  always_comb begin
    addr_d = addr_q;
    wr_d   = wr_q;
    vld_d  = vld_q;
    data_d = data_q;
    if (hready_in) begin
      for (int i = PIPE_DEPTH-1; i > 0; i--) begin
        addr_d[i] = addr_q[i-1];
        wr_d[i]   = wr_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      for (int i = DD-1; i > 0; i--) data_d[i] = data_q[i-1];
      addr_d[0] = haddr;
      wr_d[0]   = hwrite;
      vld_d[0]  = valid;
      data_d[0] = hwdata;
    end
  end

  always_ff @(posedge hclk) begin
    if (hresetn) begin
      addr_q <= '0;
      wr_q   <= '0;
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      addr_q <= addr_d;
      wr_q   <= wr_d;
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign haddr_q  = addr_q[PIPE_DEPTH-1];
  assign hwrite_q = wr_q[PIPE_DEPTH-1];
  assign valid_q  = vld_q[PIPE_DEPTH-1];
  assign hwdata_q = data_q[DD-1];

`ifdef AHB_SLV_ERR_RESP_EN
  err_st_e state_d, state_q;
  logic    err;

  // valid already folds in hready_in and htrans, so an active miss is its complement.
  assign err = hready_in & trans_active(htrans) & ~valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (err) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hresetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  assign hready_out = (state_q == ST_IDLE) ? ~bridge_busy : (state_q == ST_ERR2);
  assign hresp      = (state_q == ST_IDLE) ? HRESP_OKAY : HRESP_ERROR;
`else
  assign hready_out = ~bridge_busy;
  assign hresp      = HRESP_OKAY;
`endif

endmodule

// File: tb/tb_ahb_slave_pipe.sv
// Scoreboard bench for ahb_slave_pipe: directed bus scenarios then random
// traffic, checked against a transfer-history reference model.
module tb_ahb_slave_pipe;
  import ahb_slv_pkg::*;

  localparam int          ADDR_W  = 32;
  localparam int          DATA_W  = 32;
  localparam int          NUM_SEL = 3;
  localparam int          DEPTH   = 2;
  localparam longint      BASE    = 64'h8000_0000;
  localparam longint      RSIZE   = 64'h0400_0000;
  localparam longint      UPPER   = BASE + NUM_SEL * RSIZE;

  logic               hclk = 1'b0;
  logic               hresetn, hwrite, hready_in, bridge_busy;
  logic [1:0]         htrans;
  logic [ADDR_W-1:0]  haddr;
  logic [DATA_W-1:0]  hwdata;
  logic               hready_out, valid, hwrite_q, valid_q;
  logic [1:0]         hresp;
  logic [NUM_SEL-1:0] temp_sel;
  logic [ADDR_W-1:0]  haddr_q;
  logic [DATA_W-1:0]  hwdata_q;

  ahb_slave_pipe #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SEL(NUM_SEL),
    .BASE_ADDR(32'h8000_0000), .REGION_SIZE(32'h0400_0000), .PIPE_DEPTH(DEPTH)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hready_in(hready_in),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .bridge_busy(bridge_busy),
    .hready_out(hready_out), .hresp(hresp), .valid(valid), .temp_sel(temp_sel),
    .haddr_q(haddr_q), .hwdata_q(hwdata_q), .hwrite_q(hwrite_q), .valid_q(valid_q)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic        v;
  } ent_t;

  typedef struct {
    logic        v;
    logic [31:0] sel;
    logic        rdy;
    logic [31:0] resp;
    logic [31:0] a_q;
    logic [31:0] d_q;
    logic        w_q;
    logic        v_q;
  } exp_t;

  exp_t sbq[$];
  ent_t hist[$];  // accepted transfers, most recent first
  int   err_phase;  // 0 = responding normally, 1/2 = error beat number
  int   total = 0;
  int   bad   = 0;

  function automatic bit in_rng(input logic [31:0] a);
    longint la = longint'(a);
    return (la >= BASE) && (la < UPPER);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // One bus cycle: retire the edge into the model, then apply new inputs
  // and queue what the DUT should show for them.
  task automatic cyc(input logic rst, input logic [1:0] tr, input logic [31:0] a,
                     input logic w, input logic [31:0] d, input logic rdy, input logic busy);
    exp_t e;
    ent_t t;
    longint idx;
    @(posedge hclk);
    if (hresetn) begin
      hist.delete();
      err_phase = 0;
    end else begin
      if (hready_in) begin
        t.a = haddr; t.d = hwdata; t.w = hwrite;
        t.v = htrans[1] && in_rng(haddr);
        hist.push_front(t);
        if (hist.size() > 4) void'(hist.pop_back());
      end
`ifdef AHB_SLV_ERR_RESP_EN
      if (err_phase == 1)      err_phase = 2;
      else if (err_phase == 2) err_phase = 0;
      else if (hready_in && htrans[1] && !in_rng(haddr)) err_phase = 1;
`endif
    end
    #1;
    hresetn = rst; htrans = tr; haddr = a; hwrite = w; hwdata = d;
    hready_in = rdy; bridge_busy = busy;
    e.v   = rdy && tr[1] && in_rng(a);
    idx   = (longint'(a) - BASE) / RSIZE;
    e.sel = e.v ? (32'd1 << idx) : 32'd0;
    e.rdy = (err_phase == 0) ? !busy : (err_phase == 2);
    e.resp = (err_phase == 0) ? 32'd0 : 32'd1;
    e.a_q = (hist.size() >= DEPTH)     ? hist[DEPTH-1].a : 32'd0;
    e.w_q = (hist.size() >= DEPTH)     ? hist[DEPTH-1].w : 1'b0;
    e.v_q = (hist.size() >= DEPTH)     ? hist[DEPTH-1].v : 1'b0;
    e.d_q = (hist.size() >= DEPTH - 1) ? hist[DEPTH-2].d : 32'd0;
    sbq.push_back(e);
  endtask

  always @(negedge hclk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("valid",      {31'd0, valid},      {31'd0, e.v});
      chk("temp_sel",   {29'd0, temp_sel},   e.sel);
      chk("hready_out", {31'd0, hready_out}, {31'd0, e.rdy});
      chk("hresp",      {30'd0, hresp},      e.resp);
      chk("haddr_q",    haddr_q,             e.a_q);
      chk("hwdata_q",   hwdata_q,            e.d_q);
      chk("hwrite_q",   {31'd0, hwrite_q},   {31'd0, e.w_q});
      chk("valid_q",    {31'd0, valid_q},    {31'd0, e.v_q});
    end
  end

  function automatic logic [31:0] pick_addr();
    logic [31:0] k;
    k = 32'($urandom_range(0, NUM_SEL));
    case ($urandom_range(0, 7))
      0: return 32'(BASE);
      1: return 32'(UPPER);
      2: return 32'(UPPER - 4);
      3: return 32'(BASE - 4);
      4: return 32'(BASE) + k * 32'(RSIZE);
      5: return 32'(BASE) + k * 32'(RSIZE) - 32'd4;
      6: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    err_phase = 0;
    hresetn = 1'b1; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0;
    hwdata = '0; hready_in = 1'b1; bridge_busy = 1'b0;
    cyc(1, HTRANS_IDLE, 0, 0, 0, 1, 0);
    cyc(0, HTRANS_IDLE, 0, 0, 0, 1, 0);

    // NONSEQ write into region 1, then let it drain through the pipe
    cyc(0, HTRANS_NONSEQ, 32'h8400_0010, 1, 32'h1111_0000, 1, 0);
    cyc(0, HTRANS_IDLE,   0, 0, 32'hD00D_0001, 1, 0);
    cyc(0, HTRANS_IDLE,   0, 0, 0, 1, 0);

    // last word of region 2, then first address past the map
    cyc(0, HTRANS_NONSEQ, 32'h8BFF_FFFC, 0, 0, 1, 0);
    cyc(0, HTRANS_NONSEQ, 32'h8C00_0000, 1, 32'h2222_0000, 1, 0);
    repeat (3) cyc(0, HTRANS_IDLE, 0, 0, 0, 1, 0);

    // burst with a three-cycle hready_in stall in the middle
    for (int i = 0; i < 8; i++) begin
      if (i == 4) repeat (3) cyc(0, HTRANS_SEQ, 32'h8000_0100 + 32'(i*4), 1, 32'hAB00_0000 + 32'(i), 0, 0);
      cyc(0, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h8000_0100 + 32'(i*4), 1, 32'hAB00_0000 + 32'(i), 1, 0);
    end
    cyc(0, HTRANS_IDLE, 0, 0, 32'hAB00_0008, 1, 0);

    // out-of-range SEQ colliding with bridge_busy, then busy while idle
    cyc(0, HTRANS_SEQ,  32'hF000_0000, 0, 0, 1, 1);
    cyc(0, HTRANS_IDLE, 0, 0, 0, 1, 1);
    cyc(0, HTRANS_IDLE, 0, 0, 0, 1, 1);
    cyc(0, HTRANS_IDLE, 0, 0, 0, 1, 1);

    // reset lands while the error response is in its first beat
    cyc(0, HTRANS_NONSEQ, 32'h8000_0040, 1, 0, 1, 0);
    cyc(0, HTRANS_NONSEQ, 32'h7FFF_FFFC, 0, 32'h3333_0000, 1, 0);
    cyc(1, HTRANS_IDLE, 0, 0, 0, 1, 0);
    cyc(0, HTRANS_IDLE, 0, 0, 0, 1, 0);
    cyc(0, HTRANS_NONSEQ, 32'h0000_0000, 0, 0, 1, 0);
    cyc(0, HTRANS_BUSY,   32'h8000_0000, 1, 0, 1, 0);
    repeat (2) cyc(0, HTRANS_IDLE, 0, 0, 0, 1, 0);

    for (int n = 0; n < 1500; n++) begin
      cyc(($urandom_range(0, 63) == 0), 2'($urandom), pick_addr(), 1'($urandom),
          $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
    end
    cyc(0, HTRANS_IDLE, 0, 0, 0, 1, 0);

    repeat (3) @(negedge hclk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
